// File: rtl/mem_access_pkg.sv
// Shared core types for the memory-access stage: decoded instruction, funct3 widths and FSM states.
package mem_access_pkg;

    typedef struct packed {
        logic [6:0] opcode;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [2:0] funct3;
        logic [6:0] funct7;
        logic       is_load;
        logic       is_store;
    } instructions;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [0:0] {StIdle, StBus} mem_state_t;

    typedef enum logic [1:0] {SizeByte, SizeHalf, SizeWord} access_size_t;

    // Unsigned byte/half encodings only exist for loads; any other code is a word access.
    function automatic access_size_t access_size(input logic [2:0] funct3, input logic is_store);
        access_size_t size;
        case (funct3)
            F3_B:    size = SizeByte;
            F3_H:    size = SizeHalf;
            F3_BU:   size = is_store ? SizeWord : SizeByte;
            F3_HU:   size = is_store ? SizeWord : SizeHalf;
            default: size = SizeWord;
        endcase
        return size;
    endfunction

endpackage

// File: rtl/mem_access_if.sv
// Data-bus handshake between the memory-access stage (master) and the data memory (slave).
interface mem_access_if #(
    parameter int unsigned ADDR_W = 32
) ();
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_wstrb;
    logic              mem_ready;
    logic [31:0]       mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/mem_access_load_extender.sv
// Selects the addressed byte/half of a read word and sign- or zero-extends it by funct3.
module load_extender
    import mem_access_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[7:0];
        case (addr)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = addr[1] ? rdata[31:16] : rdata[15:0];

        case (funct3)
            F3_B:    result = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   result = {24'd0, byte_sel};
            F3_H:    result = {{16{half_sel[15]}}, half_sel};
            F3_HU:   result = {16'd0, half_sel};
            default: result = rdata;
        endcase
    end
endmodule

// File: rtl/mem_access.sv
// Memory-access stage: one optional data-bus transaction per enabled pulse, then a registered
// result with a level-held completed flag for write-back.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         enabled,
    input  instructions  instr,
    input  logic [31:0]  exec_result,
    input  logic [31:0]  rs2_data,
    mem_access_if.master bus,
    output instructions  instr_out,
    output logic [31:0]  result,
    output logic         misaligned,
    output logic         completed
);
    mem_state_t        state_q, state_d;
    instructions       instr_q, instr_d;
    logic [1:0]        addr_lo_q, addr_lo_d;
    logic [31:0]       result_q, result_d;
    logic              misaligned_q, misaligned_d;
    logic              completed_q, completed_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] maddr_q, maddr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        wstrb_q, wstrb_d;

    access_size_t size;
    logic         is_mem;
    logic         is_misaligned;
    logic [31:0]  store_wdata;
    logic [3:0]   store_wstrb;
    logic [31:0]  load_result;

    load_extender u_load_extender (
        .rdata  (bus.mem_rdata),
        .addr   (addr_lo_q),
        .funct3 (instr_q.funct3),
        .result (load_result)
    );

    always_comb begin
        size          = access_size(instr.funct3, instr.is_store);
        is_mem        = instr.is_load | instr.is_store;
        is_misaligned = is_mem && (((size == SizeHalf) && exec_result[0]) ||
                                   ((size == SizeWord) && (exec_result[1:0] != 2'b00)));
        case (size)
            SizeByte: begin
                store_wdata = {4{rs2_data[7:0]}};
                store_wstrb = 4'b0001 << exec_result[1:0];
            end
            SizeHalf: begin
                store_wdata = {2{rs2_data[15:0]}};
                store_wstrb = exec_result[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                store_wdata = rs2_data;
                store_wstrb = 4'b1111;
            end
        endcase
    end

    always_comb begin
        state_d      = state_q;
        instr_d      = instr_q;
        addr_lo_d    = addr_lo_q;
        result_d     = result_q;
        misaligned_d = misaligned_q;
        completed_d  = completed_q;
        req_d        = req_q;
        we_d         = we_q;
        maddr_d      = maddr_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;

        case (state_q)
            StIdle: begin
                if (enabled) begin
                    instr_d      = instr;
                    addr_lo_d    = exec_result[1:0];
                    completed_d  = 1'b0;
                    misaligned_d = 1'b0;
                    result_d     = '0;
                    if (!is_mem) begin
                        result_d    = exec_result;
                        completed_d = 1'b1;
                    end else if (is_misaligned) begin
                        misaligned_d = 1'b1;
                        result_d     = exec_result;
                        completed_d  = 1'b1;
                    end else begin
                        req_d   = 1'b1;
                        we_d    = instr.is_store;
                        maddr_d = ADDR_W'({exec_result[31:2], 2'b00});
                        wdata_d = instr.is_store ? store_wdata : '0;
                        wstrb_d = instr.is_store ? store_wstrb : 4'b0000;
                        state_d = StBus;
                    end
                end
            end
            StBus: begin
                if (bus.mem_ready) begin
                    req_d       = 1'b0;
                    completed_d = 1'b1;
                    result_d    = instr_q.is_load ? load_result : '0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= StIdle;
            instr_q      <= '0;
            addr_lo_q    <= '0;
            result_q     <= '0;
            misaligned_q <= 1'b0;
            completed_q  <= 1'b0;
            req_q        <= 1'b0;
            we_q         <= 1'b0;
            maddr_q      <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
        end else begin
            state_q      <= state_d;
            instr_q      <= instr_d;
            addr_lo_q    <= addr_lo_d;
            result_q     <= result_d;
            misaligned_q <= misaligned_d;
            completed_q  <= completed_d;
            req_q        <= req_d;
            we_q         <= we_d;
            maddr_q      <= maddr_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
        end
    end

    assign bus.mem_req   = req_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = maddr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_wstrb = wstrb_q;
    assign instr_out     = instr_q;
    assign result        = result_q;
    assign misaligned    = misaligned_q;
    assign completed     = completed_q;
endmodule

// File: tb/tb_mem_access.sv
// Randomized bench for mem_access: an arithmetic reference model plus a per-cycle compare process.
module tb_mem_access;
    import mem_access_pkg::*;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        enabled = 1'b0;
    instructions instr = '0;
    logic [31:0] exec_result = '0;
    logic [31:0] rs2_data = '0;
    instructions instr_out;
    logic [31:0] result;
    logic        misaligned;
    logic        completed;

    int errors = 0;
    int checks = 0;

    mem_access_if #(.ADDR_W(32)) bus ();

    mem_access #(.ADDR_W(32)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .enabled     (enabled),
        .instr       (instr),
        .exec_result (exec_result),
        .rs2_data    (rs2_data),
        .bus         (bus),
        .instr_out   (instr_out),
        .result      (result),
        .misaligned  (misaligned),
        .completed   (completed)
    );

    always #5 clk = ~clk;

    // Expectations of the operation currently in flight.
    bit          chk_active = 1'b0;
    bit          pending = 1'b0;
    bit          exp_bus, exp_we, exp_mis;
    logic [31:0] exp_addr, exp_wdata, exp_result;
    logic [3:0]  exp_wstrb;
    instructions exp_instr;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    function automatic int unsigned size_of(input instructions i);
        if (i.funct3 == 3'd0) return 1;
        if (i.funct3 == 3'd1) return 2;
        if (i.is_load && i.funct3 == 3'd4) return 1;
        if (i.is_load && i.funct3 == 3'd5) return 2;
        return 4;
    endfunction

    task automatic model(input instructions i, input logic [31:0] ex, input logic [31:0] rs2,
                         input logic [31:0] rdata, output bit bus_o, output bit we,
                         output logic [31:0] addr, output logic [31:0] wdata,
                         output logic [3:0] wstrb, output logic [31:0] res, output bit mis);
        int unsigned sz;
        int unsigned off;
        logic [31:0] mask;
        logic [31:0] v;
        logic [3:0]  base;
        bit          mem;
        sz    = size_of(i);
        off   = 32'(ex[1:0]);
        mem   = i.is_load || i.is_store;
        mis   = mem && ((ex % sz) != 0);
        bus_o = mem && !mis;
        we    = i.is_store;
        addr  = ex - off;
        wdata = '0;
        wstrb = '0;
        res   = ex;
        if (bus_o && i.is_store) begin
            base  = (sz == 1) ? 4'b0001 : (sz == 2) ? 4'b0011 : 4'b1111;
            wstrb = base << off;
            wdata = (sz == 1) ? {24'd0, rs2[7:0]} * 32'h0101_0101 :
                    (sz == 2) ? {16'd0, rs2[15:0]} * 32'h0001_0001 : rs2;
            res   = '0;
        end else if (bus_o) begin
            mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
            v    = (rdata >> (8 * off)) & mask;
            if (sz < 4 && !i.funct3[2] && v[8 * sz - 1]) v = v | ~mask;
            res = v;
        end
    endtask

    function automatic instructions mk(input bit ld, input bit st, input logic [2:0] f3);
        instructions i;
        i          = '0;
        i.opcode   = ld ? 7'h03 : st ? 7'h23 : 7'h33;
        i.rd       = 5'($urandom);
        i.rs1      = 5'($urandom);
        i.rs2      = 5'($urandom);
        i.funct3   = f3;
        i.is_load  = ld;
        i.is_store = st;
        return i;
    endfunction

    always @(negedge clk) begin
        if (chk_active && rstn) begin
            if (pending) begin
                check("bus_req", 64'(bus.mem_req), 64'd1);
                check("bus_we", 64'(bus.mem_we), 64'(exp_we));
                check("bus_addr", 64'(bus.mem_addr), 64'(exp_addr));
                check("bus_wstrb", 64'(bus.mem_wstrb), 64'(exp_wstrb));
                if (exp_we) check("bus_wdata", 64'(bus.mem_wdata), 64'(exp_wdata));
                check("busy_completed", 64'(completed), 64'd0);
            end else begin
                check("idle_req", 64'(bus.mem_req), 64'd0);
                check("completed", 64'(completed), 64'd1);
                check("result", 64'(result), 64'(exp_result));
                check("misaligned", 64'(misaligned), 64'(exp_mis));
                check("instr_out", 64'(instr_out), 64'(exp_instr));
            end
        end
    end

    task automatic run_op(input instructions i, input logic [31:0] ex, input logic [31:0] rs2,
                          input int wait_n, input logic [31:0] rdata);
        bit          b, we, mis;
        logic [31:0] addr, wdata, res;
        logic [3:0]  wstrb;
        model(i, ex, rs2, rdata, b, we, addr, wdata, wstrb, res, mis);
        @(posedge clk); #1;
        enabled     = 1'b1;
        instr       = i;
        exec_result = ex;
        rs2_data    = rs2;
        @(posedge clk); #1;
        enabled     = 1'b0;
        instr       = mk($urandom_range(0, 1) == 1, 1'b0, 3'($urandom));
        exec_result = $urandom;
        rs2_data    = $urandom;
        exp_bus = b; exp_we = we; exp_addr = addr; exp_wdata = wdata;
        exp_wstrb = wstrb; exp_result = res; exp_mis = mis; exp_instr = i;
        pending    = b;
        chk_active = 1'b1;
        if (b) begin
            for (int k = 0; k < wait_n; k++) begin
                bus.mem_ready = 1'b0;
                bus.mem_rdata = $urandom;
                enabled       = ($urandom_range(0, 1) == 1);
                @(posedge clk); #1;
            end
            enabled       = 1'b0;
            bus.mem_ready = 1'b1;
            bus.mem_rdata = rdata;
            @(posedge clk); #1;
            bus.mem_ready = 1'b0;
            bus.mem_rdata = $urandom;
            pending       = 1'b0;
        end
    endtask

    task automatic gap(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            bus.mem_ready = ($urandom_range(0, 1) == 1);
            bus.mem_rdata = $urandom;
        end
        bus.mem_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        instructions i;
        logic [31:0] ex;
        bit          ld, st;
        logic [2:0]  f3;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        #1;
        check("rst_completed", 64'(completed), 64'd0);
        check("rst_req", 64'(bus.mem_req), 64'd0);
        check("rst_we", 64'(bus.mem_we), 64'd0);
        check("rst_addr", 64'(bus.mem_addr), 64'd0);
        check("rst_wdata", 64'(bus.mem_wdata), 64'd0);
        check("rst_wstrb", 64'(bus.mem_wstrb), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        check("rst_misaligned", 64'(misaligned), 64'd0);
        check("rst_instr_out", 64'(instr_out), 64'd0);
        #16 rstn = 1'b1;

        run_op(mk(0, 0, 3'd0), 32'h0000_1234, 32'h0, 0, 32'h0);
        check("add_model", 64'(exp_result), 64'h1234);
        check("add_result", 64'(result), 64'h1234);
        check("add_completed", 64'(completed), 64'd1);

        run_op(mk(1, 0, F3_B), 32'h0000_0103, 32'h0, 3, 32'h80FF_FF00);
        check("lb_model_addr", 64'(exp_addr), 64'h100);
        check("lb_result", 64'(result), 64'hFFFF_FF80);
        check("lb_completed", 64'(completed), 64'd1);

        run_op(mk(1, 0, F3_HU), 32'h0000_0202, 32'h0, 1, 32'hBEEF_1234);
        check("lhu_result", 64'(result), 64'h0000_BEEF);
        run_op(mk(1, 0, F3_H), 32'h0000_0200, 32'h0, 0, 32'hBEEF_1234);
        check("lh_result", 64'(result), 64'h0000_1234);

        run_op(mk(0, 1, F3_B), 32'h0000_0301, 32'hAABB_CCDD, 5, 32'h0);
        check("sb_model_wdata", 64'(exp_wdata), 64'hDDDD_DDDD);
        check("sb_model_wstrb", 64'(exp_wstrb), 64'b0010);
        check("sb_result", 64'(result), 64'd0);

        run_op(mk(1, 0, F3_W), 32'h0000_0402, 32'h0, 0, 32'h0);
        check("lw_misaligned", 64'(misaligned), 64'd1);
        check("lw_completed", 64'(completed), 64'd1);
        run_op(mk(0, 0, 3'd0), 32'h0000_0055, 32'h0, 0, 32'h0);
        check("add_clears_mis", 64'(misaligned), 64'd0);

        for (int n = 0; n < 200; n++) begin
            case ($urandom_range(0, 2))
                0:       begin ld = 1'b0; st = 1'b0; f3 = 3'($urandom); end
                1:       begin ld = 1'b1; st = 1'b0; f3 = 3'($urandom); end
                default: begin
                    ld = 1'b0; st = 1'b1;
                    f3 = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'($urandom_range(0, 2));
                end
            endcase
            i  = mk(ld, st, f3);
            ex = $urandom;
            if ($urandom_range(0, 1) == 1) ex[1:0] = 2'b00;
            run_op(i, ex, $urandom, $urandom_range(0, 4), $urandom);
            gap($urandom_range(0, 2));
        end

        // Reset while a store waits on the bus; a second enabled in BUS must be ignored.
        gap(1);
        chk_active    = 1'b0;
        bus.mem_ready = 1'b0;
        @(posedge clk); #1;
        enabled     = 1'b1;
        instr       = mk(0, 1, F3_W);
        exec_result = 32'h0000_0500;
        rs2_data    = 32'h1122_3344;
        @(posedge clk); #1;
        instr       = mk(0, 0, 3'd0);
        exec_result = 32'h0000_0777;
        check("sw_req", 64'(bus.mem_req), 64'd1);
        @(posedge clk); #1;
        enabled = 1'b0;
        check("ignored_en_req", 64'(bus.mem_req), 64'd1);
        check("ignored_en_addr", 64'(bus.mem_addr), 64'h500);
        check("ignored_en_completed", 64'(completed), 64'd0);
        #2 rstn = 1'b0;
        #1;
        check("arst_req", 64'(bus.mem_req), 64'd0);
        check("arst_completed", 64'(completed), 64'd0);
        check("arst_wstrb", 64'(bus.mem_wstrb), 64'd0);
        check("arst_result", 64'(result), 64'd0);
        @(posedge clk); #1;
        rstn = 1'b1;
        run_op(mk(0, 0, 3'd0), 32'hCAFE_0001, 32'h0, 0, 32'h0);
        check("post_rst_result", 64'(result), 64'hCAFE_0001);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
